// File: rtl/volume_window_ctrl.sv
// Mic volume window controller: per-window peak magnitude about mid-scale,
// peak-hold with decay, and a 12-LED thermometer bar.
module volume_window_ctrl #(
  parameter int DATA_W       = 12,
  parameter int WIN_W        = 12,
  parameter int DEFAULT_WIN  = 2500,
  parameter int MID          = 2048,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic              clk_20k,
  input  logic              rst_n,
  input  logic              en,
  input  logic              freeze,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [DATA_W-1:0] mic,
  output logic [DATA_W-1:0] peak,
  output logic              peak_valid,
  output logic [3:0]        level,
  output logic [11:0]       led
);

  localparam int HOLD_W  = $clog2(HOLD_WINDOWS + 1);
  localparam int LVL_MAX = 12;
  localparam logic [DATA_W-1:0] MID_C = DATA_W'(MID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FROZEN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_acc_max;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0]  r_win_len_l;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_peak;
  logic              r_peak_valid;
  logic [3:0]        r_level;
  logic [11:0]       r_led;

  logic              w_clear;
  logic              w_latch_len;
  logic              w_process;
  logic              w_last;
  logic [WIN_W-1:0]  w_len_req;
  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] w_m;
  logic [DATA_W-1:0] w_decay;
  logic [DATA_W-1:0] w_disp_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [DATA_W-8:0] w_lvl_raw;
  logic [3:0]        w_level;
  logic [11:0]       w_led;

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state / control decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_latch_len = 1'b0;
    w_process   = 1'b0;
    if (!en) begin
      // Disable outranks freeze and wipes all window and display state.
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RUN;
          w_latch_len = 1'b1;
        end
        S_RUN: begin
          if (freeze) begin
            w_state_nxt = S_FROZEN;
          end else begin
            w_process = 1'b1;
          end
        end
        S_FROZEN: begin
          if (!freeze) begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Window datapath
  // ---------------------------------------------------------------------------
  assign w_len_req = (win_len == '0) ? WIN_W'(1) : win_len;
  assign w_mag     = (mic >= MID_C) ? (mic - MID_C) : (MID_C - mic);
  assign w_m       = (w_mag > r_acc_max) ? w_mag : r_acc_max;
  assign w_last    = (r_win_cnt == (r_win_len_l - WIN_W'(1)));

  // Peak-hold decision for the window that completes on this edge.
  always_comb begin
    w_disp_nxt = r_disp;
    w_hold_nxt = r_hold_cnt;
    w_decay    = ((r_disp >> 3) == '0) ? DATA_W'(1) : (r_disp >> 3);
    if (w_m >= r_disp) begin
      w_disp_nxt = w_m;
      w_hold_nxt = HOLD_W'(HOLD_WINDOWS);
    end else if (r_hold_cnt != '0) begin
      w_hold_nxt = r_hold_cnt - HOLD_W'(1);
    end else if (r_disp != '0) begin
      // w_decay never exceeds a non-zero r_disp, so this cannot wrap.
      w_disp_nxt = r_disp - w_decay;
    end
  end

  // ---------------------------------------------------------------------------
  // Bar level and thermometer
  // ---------------------------------------------------------------------------
  assign w_lvl_raw = r_disp[DATA_W-1:7];
  assign w_level   = (int'(w_lvl_raw) > LVL_MAX) ? 4'(LVL_MAX) : w_lvl_raw[3:0];

  always_comb begin
    w_led = '0;
    for (int i = 0; i < 12; i++) begin
      w_led[i] = (i < int'(w_level));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_max    <= '0;
      r_win_cnt    <= '0;
      r_win_len_l  <= WIN_W'(DEFAULT_WIN);
      r_hold_cnt   <= '0;
      r_disp       <= '0;
      r_peak       <= '0;
      r_peak_valid <= 1'b0;
      r_level      <= '0;
      r_led        <= '0;
    end else if (w_clear) begin
      r_acc_max    <= '0;
      r_win_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_disp       <= '0;
      r_peak       <= '0;
      r_peak_valid <= 1'b0;
      r_level      <= '0;
      r_led        <= '0;
    end else begin
      r_peak_valid <= 1'b0;
      r_level      <= w_level;
      r_led        <= w_led;
      if (w_latch_len) begin
        r_win_len_l <= w_len_req;
      end
      if (w_process) begin
        if (w_last) begin
          r_peak       <= w_m;
          r_peak_valid <= 1'b1;
          r_acc_max    <= '0;
          r_win_cnt    <= '0;
          r_win_len_l  <= w_len_req;
          r_disp       <= w_disp_nxt;
          r_hold_cnt   <= w_hold_nxt;
        end else begin
          r_acc_max <= w_m;
          r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
      end
    end
  end

  assign peak       = r_peak;
  assign peak_valid = r_peak_valid;
  assign level      = r_level;
  assign led        = r_led;

endmodule

// File: tb/tb_volume_window_ctrl.sv
// Directed self-checking bench for volume_window_ctrl with hand-computed
// expected values for windowing, peak-hold/decay, freeze and enable.
module tb_volume_window_ctrl;

  localparam int DATA_W = 12;
  localparam int WIN_W  = 12;

  logic              clk_20k;
  logic              rst_n;
  logic              en;
  logic              freeze;
  logic [WIN_W-1:0]  win_len;
  logic [DATA_W-1:0] mic;
  logic [DATA_W-1:0] peak;
  logic              peak_valid;
  logic [3:0]        level;
  logic [11:0]       led;

  int n_checks = 0;
  int n_errors = 0;

  volume_window_ctrl #(
    .DATA_W      (DATA_W),
    .WIN_W       (WIN_W),
    .DEFAULT_WIN (2500),
    .MID         (2048),
    .HOLD_WINDOWS(4)
  ) dut (
    .clk_20k   (clk_20k),
    .rst_n     (rst_n),
    .en        (en),
    .freeze    (freeze),
    .win_len   (win_len),
    .mic       (mic),
    .peak      (peak),
    .peak_valid(peak_valid),
    .level     (level),
    .led       (led)
  );

  initial clk_20k = 1'b0;
  always #5 clk_20k = ~clk_20k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_20k);
    #1;
  endtask

  // en low for one edge (clears everything), then the IDLE->RUN edge latches len.
  task automatic restart(input logic [WIN_W-1:0] len);
    mic = 12'd2048;
    en  = 1'b0;
    tick();
    win_len = len;
    en      = 1'b1;
    tick();
  endtask

  int lvl_exp [8] = '{8, 8, 8, 8, 8, 7, 6, 5};
  int mic_t2  [4] = '{2048, 2100, 1900, 2050};

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    freeze  = 1'b0;
    win_len = 12'd4;
    mic     = 12'd2048;
    tick();
    tick();
    check("rst_peak", peak, 0);
    check("rst_pv", peak_valid, 0);
    check("rst_level", level, 0);
    check("rst_led", led, 0);
    rst_n = 1'b1;

    // Basic 4-sample window: magnitudes 0,52,148,2 -> peak 148.
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      mic = 12'(mic_t2[i]);
      tick();
      if (i == 2) check("w4_pv_early", peak_valid, 0);
    end
    check("w4_peak", peak, 148);
    check("w4_pv", peak_valid, 1);
    mic = 12'd2048;
    tick();
    check("w4_pv_pulse", peak_valid, 0);
    check("w4_level", level, 1);
    check("w4_led", led, 12'h001);

    // Asynchronous reset in the middle of a window.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_peak", peak, 0);
    check("arst_level", level, 0);
    check("arst_led", led, 0);
    check("arst_pv", peak_valid, 0);
    win_len = 12'd2500;
    mic     = 12'd2053;
    rst_n   = 1'b1;
    begin
      int  edges = 0;
      bit  seen  = 1'b0;
      while (!seen && edges < 3000) begin
        tick();
        edges++;
        if (peak_valid) seen = 1'b1;
      end
      // One IDLE->RUN edge plus 2500 sample edges.
      check("win2500_edges", edges, 2501);
      check("win2500_peak", peak, 5);
    end

    // Single-sample windows at full negative swing: clipped bar.
    restart(12'd0);
    mic = 12'd0;
    tick();
    check("w1_pv_a", peak_valid, 1);
    check("w1_peak", peak, 2048);
    tick();
    check("w1_pv_b", peak_valid, 1);
    check("w1_level", level, 12);
    check("w1_led", led, 12'hFFF);

    // Peak-hold for 4 windows then decay 1024 -> 896 -> 784 -> 686.
    restart(12'd1);
    mic = 12'd3072;
    tick();
    check("hold_peak", peak, 1024);
    mic = 12'd2048;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("hold_level_%0d", k), level, lvl_exp[k]);
    end
    repeat (100) tick();
    check("decay_level0", level, 0);
    check("decay_led0", led, 0);
    check("decay_peak0", peak, 0);

    // Freeze after 3 samples; spike during freeze must be ignored.
    restart(12'd8);
    mic = 12'd2058; tick();
    mic = 12'd2068; tick();
    mic = 12'd2078; tick();
    check("frz_pv_pre", peak_valid, 0);
    freeze = 1'b1;
    mic    = 12'd0;
    begin
      int pv_hits = 0;
      repeat (100) begin
        tick();
        if (peak_valid) pv_hits++;
      end
      check("frz_pv_hits", pv_hits, 0);
    end
    check("frz_peak_hold", peak, 0);
    freeze = 1'b0;
    mic    = 12'd2053;
    tick();
    mic = 12'd2088; tick();
    mic = 12'd2098; tick();
    mic = 12'd2048; tick();
    tick();
    check("frz_pv_4th", peak_valid, 0);
    tick();
    check("frz_pv_5th", peak_valid, 1);
    check("frz_peak", peak, 50);

    // Length change mid-window applies only from the next window.
    restart(12'd8);
    mic = 12'd2148; tick();
    mic = 12'd2048;
    win_len = 12'd16;
    tick();
    repeat (5) tick();
    check("len_pv_7th", peak_valid, 0);
    tick();
    check("len_pv_8th", peak_valid, 1);
    check("len_peak_a", peak, 100);
    for (int s = 1; s <= 16; s++) begin
      mic = (s == 5) ? 12'd1748 : 12'd2048;
      tick();
      if (s == 8)  check("len_pv_b8", peak_valid, 0);
      if (s == 15) check("len_pv_b15", peak_valid, 0);
    end
    check("len_pv_b16", peak_valid, 1);
    check("len_peak_b", peak, 300);
    mic = 12'd2048;
    tick();
    check("len_level", level, 2);
    check("len_led", led, 12'h003);

    // One edge of en=0 clears the outputs without a peak_valid pulse.
    en = 1'b0;
    tick();
    check("dis_peak", peak, 0);
    check("dis_level", level, 0);
    check("dis_led", led, 0);
    check("dis_pv", peak_valid, 0);
    en = 1'b1;
    tick();
    check("dis_pv_resume", peak_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
